register_file_mp: RTL and testbench

- Parametrised multi-read-port register file with one write port. Next generation of the core's register file.
- Adds over the previous generation: configurable read-port count, per-port read enables with valid flags, optional write-to-read bypass, optional hardwired zero entry, and a post-reset hardware clear sequencer.
- Sits between decode (read addresses) and writeback (write port) in the pipeline.

---
 rtl/register_file_mp.sv | 133 +++++++++++++
 tb/tb_register_file_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-read-port register file with a single write port. It sits between
//   decode (read addresses) and writeback (write port). After reset, a clear
//   sequencer writes zero to every entry. Writes are refused until the clear
//   has finished.
//
//   State table:
//     state | meaning
//     CLEAR | sequencer writes 0 to entry[clr_ptr], one entry per cycle;
//           | writes refused, reads return no data
//     READY | normal operation; left only by reset
//
//   Ports:
//     clk        clock, all logic on the rising edge
//     reset      synchronous active-high reset
//     rd_en      per-port read request            [NUM_RD]
//     rd_addr    read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//     rd_data    registered read data, port p at [p*WIDTH +: WIDTH]
//     rd_valid   registered, rd_data of port p valid this cycle
//     wr_en      write request
//     wr_addr    write address
//     wr_data    write data
//     wr_ready   writes accepted (= ~init_busy)
//     init_busy  clear sequencer active
//     wr_err     sticky flag, write attempted while busy; cleared by reset
module register_file_mp #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]      rd_data,
   output logic [NUM_RD-1:0]            rd_valid,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [WIDTH-1:0]             wr_data,
   output logic                         wr_ready,
   output logic                         init_busy,
   output logic                         wr_err
);

   localparam int SIZE = 2 ** ADDR_WIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   clr_ptr, clr_ptr_next;
   logic                    clr_last;
   logic                    wr_accept;
   logic [WIDTH-1:0]        mem [SIZE];
   logic [NUM_RD*WIDTH-1:0] rd_next;

   assign clr_last  = (clr_ptr == ADDR_WIDTH'(SIZE - 1));
   assign init_busy = (state == CLEAR);
   assign wr_ready  = ~init_busy;

   // A write to the hardwired zero entry is dropped silently, without raising an error.
   assign wr_accept = (state == READY) && wr_en &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_next;
         clr_ptr <= clr_ptr_next;
      end
   end

   always_comb begin
      state_next   = state;
      clr_ptr_next = clr_ptr;
      case (state)
         CLEAR: begin
            clr_ptr_next = clr_ptr + 1'b1;
            if (clr_last) state_next = READY;
         end
         READY: state_next = READY;
         default: state_next = CLEAR;
      endcase
   end

   // The array has no reset. It is cleared by the sequencer only after reset is released.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR)
            mem[clr_ptr] <= '0;
         else if (wr_accept)
            mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         wr_err <= 1'b0;
      else if (wr_en && (state == CLEAR))
         wr_err <= 1'b1;
   end

   // Per-port read mux. The zero entry takes priority over bypass. Bypass
   // forwards only the write accepted in this cycle.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_next[p*WIDTH +: WIDTH] =
         ((ZERO_REG != 0) && (addr == '0))              ? '0      :
         ((BYPASS != 0) && wr_accept && (wr_addr == addr)) ? wr_data :
                                                            mem[addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= '0;
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            if ((state == READY) && rd_en[p]) begin
               rd_data[p*WIDTH +: WIDTH] <= rd_next[p*WIDTH +: WIDTH];
               rd_valid[p]               <= 1'b1;
            end else begin
               rd_valid[p] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Self-checking bench for register_file_mp with ADDR_WIDTH=3 and two read
//   ports. For every cycle, a reference model pushes the expected outputs into
//   a scoreboard queue. The entry is popped and compared just after the clock edge.
module tb_register_file_mp;

   localparam int WIDTH    = 32;
   localparam int AW       = 3;
   localparam int NRD      = 2;
   localparam int BYPASS_P = 1;
   localparam int ZERO_P   = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NRD-1:0]       rd_en;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*WIDTH-1:0] rd_data;
   logic [NRD-1:0]       rd_valid;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 wr_ready;
   logic                 init_busy;
   logic                 wr_err;

   register_file_mp #(
      .WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_RD(NRD),
      .BYPASS(BYPASS_P), .ZERO_REG(ZERO_P)
   ) dut (
      .clk(clk), .reset(reset),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .init_busy(init_busy), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  valid;
      logic        busy;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] m_mem [8];
   logic [31:0] m_hold [2];
   logic        m_ready;
   logic [2:0]  m_ptr;
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [1:0] ren,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic wen, input logic [2:0] wa, input logic [31:0] wd);
      exp_t        e;
      logic        acc;
      logic [2:0]  a;
      reset   = rst;
      rd_en   = ren;
      rd_addr = {a1, a0};
      wr_en   = wen;
      wr_addr = wa;
      wr_data = wd;
      e.valid = 2'b00;
      if (rst) begin
         m_hold[0] = '0;
         m_hold[1] = '0;
         m_err     = 1'b0;
         m_ready   = 1'b0;
         m_ptr     = '0;
      end else begin
         acc = m_ready && wen && (wa != 3'd0);
         for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? a0 : a1;
            if (m_ready && ren[p]) begin
               e.valid[p] = 1'b1;
               if (a == 3'd0)                          m_hold[p] = '0;
               else if (BYPASS_P != 0 && acc && wa == a) m_hold[p] = wd;
               else                                    m_hold[p] = m_mem[a];
            end
         end
         if (wen && !m_ready) m_err = 1'b1;
         if (!m_ready) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == 3'd7) m_ready = 1'b1;
            m_ptr = m_ptr + 3'd1;
         end else if (acc) begin
            m_mem[wa] = wd;
         end
      end
      e.d0   = m_hold[0];
      e.d1   = m_hold[1];
      e.busy = !m_ready;
      e.err  = m_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("init_busy", {31'd0, init_busy}, {31'd0, e.busy});
      check("wr_ready",  {31'd0, wr_ready},  {31'd0, !e.busy});
      check("wr_err",    {31'd0, wr_err},    {31'd0, e.err});
      check("rd_valid",  {30'd0, rd_valid},  {30'd0, e.valid});
      check("rd_data0",  rd_data[31:0],      e.d0);
      check("rd_data1",  rd_data[63:32],     e.d1);
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic wr(input logic [2:0] wa, input logic [31:0] wd);
      step(1'b0, 2'b00, 3'd0, 3'd0, 1'b1, wa, wd);
   endtask

   task automatic rd2(input logic [2:0] a0, input logic [2:0] a1);
      step(1'b0, 2'b11, a0, a1, 1'b0, 3'd0, 32'd0);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && init_busy; i++) idle();
      check("ready_timeout", {31'd0, init_busy}, 32'd0);
   endtask

   task automatic count_busy(input string tag);
      int cnt = 0;
      for (int i = 0; i < 20 && init_busy; i++) begin
         cnt++;
         idle();
      end
      check(tag, cnt, 32'd8);
   endtask

   initial begin
      reset = 1'b1; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      m_ready = 1'b0; m_ptr = '0; m_err = 1'b0; m_hold[0] = '0; m_hold[1] = '0;
      for (int i = 0; i < 8; i++) m_mem[i] = 'x;

      // 1: reset for two cycles, then clear takes exactly 8 cycles
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      check("rst_rd_data", rd_data[31:0], 32'd0);
      count_busy("t1_busy_len");
      for (int i = 0; i < 8; i++) begin
         rd2(3'(i), 3'(i));
         check("t1_clear_val", rd_data[63:32], 32'd0);
      end

      // 2: basic write and two-port read, then a read with no enables
      wr(3'd5, 32'hDEADBEEF);
      wr(3'd3, 32'h12345678);
      rd2(3'd5, 3'd3);
      check("t2_p0", rd_data[31:0], 32'hDEADBEEF);
      check("t2_p1", rd_data[63:32], 32'h12345678);
      check("t2_valid", {30'd0, rd_valid}, 32'd3);
      idle();
      check("t2_hold", rd_data[31:0], 32'hDEADBEEF);
      check("t2_novalid", {30'd0, rd_valid}, 32'd0);
      rd2(3'd3, 3'd3);

      // 3: same-cycle write/read collision on entry 7
      wr(3'd7, 32'h1);
      step(1'b0, 2'b01, 3'd7, 3'd0, 1'b1, 3'd7, 32'hA5A5A5A5);
      check("t3_collide", rd_data[31:0], (BYPASS_P != 0) ? 32'hA5A5A5A5 : 32'h1);
      rd2(3'd7, 3'd7);
      check("t3_after", rd_data[31:0], 32'hA5A5A5A5);

      // 4: hardwired zero entry
      wr(3'd0, 32'hFFFFFFFF);
      rd2(3'd0, 3'd0);
      check("t4_zero_p0", rd_data[31:0], 32'd0);
      check("t4_zero_p1", rd_data[63:32], 32'd0);
      check("t4_no_err", {31'd0, wr_err}, 32'd0);
      step(1'b0, 2'b11, 3'd0, 3'd0, 1'b1, 3'd0, 32'hCAFEF00D);
      check("t4_zero_byp", rd_data[31:0], 32'd0);

      // 5: write while the sequencer is busy
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      idle(); idle(); idle();
      wr(3'd2, 32'h55);
      check("t5_err_set", {31'd0, wr_err}, 32'd1);
      wait_ready();
      check("t5_err_held", {31'd0, wr_err}, 32'd1);
      rd2(3'd2, 3'd1);
      check("t5_addr2", rd_data[31:0], 32'd0);
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      check("t5_err_clr", {31'd0, wr_err}, 32'd0);
      wait_ready();

      // 6: reset in the middle of a clear restarts it from entry 0
      for (int i = 0; i < 8; i++) wr(3'(i), 32'hFF);
      rd2(3'd6, 3'd1);
      check("t6_filled", rd_data[31:0], 32'hFF);
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      idle(); idle(); idle(); idle();
      step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0);
      count_busy("t6_busy_len");
      for (int i = 0; i < 8; i++) begin
         rd2(3'(i), 3'(7 - i));
         check("t6_cleared", rd_data[31:0], 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
